// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the bit-counter sizing rule.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must reach WIDTH after the final RUN edge.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle between a controller and serial_addsub.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, sub,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, sub,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder cell, shared with the combinational adder family.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract, one bit per clock, LSB first.
// Results are published only on completion; the working sum stays internal.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; last result held on the outputs
// ST_RUN  | one full-adder step per edge, WIDTH edges in total
// ST_DONE | result valid, done pulse; start here is accepted directly
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_acc_next;

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    assign w_acc_next = {w_fa_sum, r_acc[WIDTH-1:1]};

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_last       = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_last;
            if (w_accept) begin
                // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
                r_a     <= bus.a;
                r_b     <= bus.sub ? ~bus.b : bus.b;
                r_carry <= bus.sub;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_acc   <= w_acc_next;
                r_carry <= w_fa_cout;
                r_cnt   <= r_cnt + CNT_ONE;
                if (w_last) begin
                    // r_carry here is the carry into the MSB.
                    r_busy <= 1'b0;
                    r_sum  <= w_acc_next;
                    r_cout <= w_fa_cout;
                    r_ovf  <= r_carry ^ w_fa_cout;
                end
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and exhaustive checks of serial_addsub at WIDTH=8 and WIDTH=4.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    res_t q8[$];
    res_t q4[$];

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) bus8 ();
    serial_addsub_if #(.WIDTH(4)) bus4 ();

    serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_addsub #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Reference built from unsigned compare and operand/result signs.
    function automatic res_t ref_model(input int w, input longint ai, input longint bi, input bit sub);
        res_t   r;
        longint mask;
        longint av;
        longint bv;
        longint s;
        bit     sa;
        bit     sb;
        bit     ss;
        mask = (longint'(1) << w) - 1;
        av   = ai & mask;
        bv   = bi & mask;
        if (sub) begin
            s      = (av - bv) & mask;
            r.cout = (av >= bv);
        end else begin
            s      = (av + bv) & mask;
            r.cout = ((av + bv) > mask);
        end
        sa    = av[w-1];
        sb    = bv[w-1];
        ss    = s[w-1];
        r.ovf = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        r.sum = 64'(s);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sub);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.sub   = sub;
        q8.push_back(ref_model(8, longint'(a), longint'(b), sub));
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic sub);
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.sub   = sub;
        q4.push_back(ref_model(4, longint'(a), longint'(b), sub));
    endtask

    task automatic wait_done8(input string tag, input int exp_lat, input int exp_busy);
        int   lat   = 0;
        int   nbusy = 0;
        bit   seen  = 1'b0;
        res_t e;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus8.start = 1'b0;
            if (bus8.busy) nbusy++;
            if (bus8.done) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 64'(bus8.done), 64'd1);
            return;
        end
        e = q8.pop_front();
        chk({tag, "_sum"}, 64'(bus8.sum), e.sum);
        chk({tag, "_cout"}, 64'(bus8.cout), 64'(e.cout));
        chk({tag, "_ovf"}, 64'(bus8.overflow), 64'(e.ovf));
        if (exp_lat > 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (exp_busy > 0) chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_busy));
    endtask

    task automatic wait_done4(input string tag);
        int   lat  = 0;
        bit   seen = 1'b0;
        res_t e;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus4.start = 1'b0;
            if (bus4.done) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 64'(bus4.done), 64'd1);
            return;
        end
        e = q4.pop_front();
        chk({tag, "_sum"}, 64'(bus4.sum), e.sum);
        chk({tag, "_cout"}, 64'(bus4.cout), 64'(e.cout));
        chk({tag, "_ovf"}, 64'(bus4.overflow), 64'(e.ovf));
        chk({tag, "_latency"}, 64'(lat), 64'd5);
    endtask

    initial begin
        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.sub   = 1'b0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus4.sub   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus8.busy), 64'd0);
        chk("rst_done", 64'(bus8.done), 64'd0);
        chk("rst_sum", 64'(bus8.sum), 64'd0);
        chk("rst_cout", 64'(bus8.cout), 64'd0);
        chk("rst_ovf", 64'(bus8.overflow), 64'd0);
        chk("rst_state", 64'(dut8.r_state), 64'(ST_IDLE));
        chk("rst_w4_sum", 64'(bus4.sum), 64'd0);
        rst = 1'b0;

        // Basic add with latency, busy length and done pulse width.
        drive8(8'h05, 8'h03, 1'b0);
        wait_done8("add_05_03", 9, 8);
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse_low", 64'(bus8.done), 64'd0);
        chk("idle_busy_low", 64'(bus8.busy), 64'd0);
        chk("sum_hold", 64'(bus8.sum), 64'h08);

        drive8(8'hFF, 8'h01, 1'b0);
        wait_done8("add_ff_01", 9, 8);
        drive8(8'h7F, 8'h01, 1'b0);
        wait_done8("add_7f_01", 9, 8);
        drive8(8'h05, 8'h07, 1'b1);
        wait_done8("sub_05_07", 9, 8);
        drive8(8'h80, 8'h01, 1'b1);
        wait_done8("sub_80_01", 9, 8);

        // start during RUN must be ignored.
        drive8(8'h11, 8'h22, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus8.start = 1'b1;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
        bus8.sub   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        chk("ignored_busy", 64'(bus8.busy), 64'd1);
        chk("ignored_sum_hold", 64'(bus8.sum), 64'h7F);
        wait_done8("ignored_start", -1, -1);

        // Back-to-back: start in the done cycle.
        drive8(8'h40, 8'h0C, 1'b1);
        wait_done8("b2b", 9, 8);

        // Reset on the 4th RUN edge aborts.
        drive8(8'h33, 8'h44, 1'b0);
        void'(q8.pop_back());
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 64'(bus8.busy), 64'd0);
        chk("abort_done", 64'(bus8.done), 64'd0);
        chk("abort_sum", 64'(bus8.sum), 64'd0);
        chk("abort_cout", 64'(bus8.cout), 64'd0);
        chk("abort_ovf", 64'(bus8.overflow), 64'd0);
        chk("abort_state", 64'(dut8.r_state), 64'(ST_IDLE));
        rst = 1'b0;
        drive8(8'h10, 8'h20, 1'b0);
        wait_done8("after_abort", 9, 8);

        // Exhaustive WIDTH=4 sweep.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    drive4(4'(i), 4'(j), 1'(s));
                    wait_done4("w4");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial two's-complement adder/subtractor for WIDTH-bit operands, processing one bit per clock, LSB first.
- Reuses the team's existing combinational full_adder cell and stores the carry in a flop, trading latency for area.
- Sits beside the combinational adder family as the first sequential, parametrised member, with a start/busy/done handshake for control-path use.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled on a rising edge of clk.
- a  input  WIDTH  operand A; sampled only when start is accepted.
- b  input  WIDTH  operand B; sampled only when start is accepted.
- sub  input  1  0 = A+B, 1 = A-B; sampled only when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result (A+B or A-B, modulo 2^WIDTH).
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk.
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0; FSM=IDLE; bit counter=0; carry flop=0.
- FSM states:
  - IDLE: start=1 -> RUN. Latch a into shift reg A and (sub ? ~b : b) into shift reg B. Set carry = sub. Clear the sum shift reg. Set busy=1.
  - RUN: each edge computes one full_adder(A[0], B[0], carry):
    - the sum bit shifts into the sum reg MSB; A and B shift right;
    - carry is updated;
    - carry-in of bit WIDTH-1 is captured for overflow;
    - counter increments.
    - After the WIDTH-th RUN edge: go to DONE, busy=0, done=1; sum, cout and overflow are updated on that same edge.
  - DONE: lasts one cycle; done deasserts on the next edge.
    - start=1 in DONE is accepted exactly as in IDLE, so back-to-back operation is supported.
    - Otherwise go to IDLE.
- Latency: start sampled at edge t0 -> done high during the cycle after edge t0+WIDTH, i.e. WIDTH+1 edges after request.
- Throughput: one operation per WIDTH+1 cycles.
- start while busy=1 is ignored. Operand inputs are don't-care except on the accepting edge.
- sum, cout and overflow hold their last result until the next accepted operation completes. They never show partial results; the working sum reg is internal.
- rst asserted in any state, including mid-RUN, aborts the operation and restores all reset values on that edge. rst dominates start.
- Width rules:
  - The counter is $clog2(WIDTH+1) bits.
  - No result width growth; the carry is reported only via cout.

Decomposition:
- Package serial_addsub_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - a counter-width function based on $clog2.
- One sub-module: the existing full_adder (ports a, b, cin, sum, cout), instantiated once as the per-bit datapath.

Test Plan:
- WIDTH=8, a=8'h05, b=8'h03, sub=0 -> done exactly 9 edges after start; sum=8'h08, cout=0, overflow=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, cout=1, overflow=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, overflow=1.
- Subtract: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, overflow=0. Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, overflow=1.
- Handshake: pulse start again at cycle 3 of RUN with different operands -> ignored, first result unchanged. Assert start in the done cycle -> second op accepted; its done arrives 9 edges later.
- rst=1 at the 4th RUN edge -> busy, done, sum, cout and overflow all 0 on that edge and FSM in IDLE. A following op a=8'h10, b=8'h20 -> sum=8'h30.
- WIDTH=4: exhaustive sweep of all 256 (a,b) pairs for both sub values, compared against a behavioural reference for sum, cout and overflow.
